// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
// Multi-digit 7-segment hex display controller for the PS/2 display path.
// Nibbles shift into a shadow register and are committed to a visible
// display register. The registered seg bus drives NUM_DIGITS active-low digits
// (bit0 = a .. bit6 = g), and the display can optionally blink.
//
// Build option:
//   HEX_LZ_BLANK_EN  when defined, digits at or above the committed digit
//                    count are blanked. When undefined, every digit shows
//                    its nibble, so an empty display reads as all zeros.
//
// Blink FSM
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   BLINK_ON  | digits visible; also the forced state while blink_en = 0
//   BLINK_OFF | all digits blank for BLINK_DIV cycles
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [3:0]              wr_data,
    input  logic                    commit,
    input  logic                    clear,
    input  logic                    blink_en,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    overflow
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int BC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIGITS);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BLINK_DIV - 1);

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_state_t;

    logic [NUM_DIGITS-1:0][3:0] sh;
    logic [CNT_W-1:0]           sc;
    logic [NUM_DIGITS-1:0][3:0] dr;
    logic [CNT_W-1:0]           dc;

    blink_state_t               blink_state;
    blink_state_t               blink_state_nxt;
    logic [BC_W-1:0]            bc;
    logic [BC_W-1:0]            bc_nxt;

    logic [7*NUM_DIGITS-1:0]    seg_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Shadow register: clear has priority over a write; the write past a full
    // count drops the oldest digit and latches the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh       <= '0;
            sc       <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            sh       <= '0;
            sc       <= '0;
            overflow <= 1'b0;
        end else if (wr_en) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                sh[i] <= sh[i-1];
            end
            sh[0] <= wr_data;
            if (sc == CNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                sc <= sc + CNT_W'(1);
            end
        end
    end

    // Display register: commit captures the shadow as it stood before this edge,
    // so a same-cycle write or clear only affects the next commit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dr <= '0;
            dc <= '0;
        end else if (commit) begin
            dr <= sh;
            dc <= sc;
        end
    end

    // Blink state and phase counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            blink_state <= BLINK_ON;
            bc          <= '0;
        end else begin
            blink_state <= blink_state_nxt;
            bc          <= bc_nxt;
        end
    end

    // Blink next state: counter wraps at BLINK_DIV-1 and toggles the phase;
    // with blink disabled the FSM is parked in ON with the counter at zero.
    always_comb begin
        blink_state_nxt = blink_state;
        bc_nxt          = bc;
        if (!blink_en) begin
            blink_state_nxt = BLINK_ON;
            bc_nxt          = '0;
        end else if (bc == BC_LAST) begin
            bc_nxt          = '0;
            blink_state_nxt = (blink_state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end else begin
            bc_nxt          = bc + BC_W'(1);
        end
    end

`ifdef HEX_LZ_BLANK_EN
    // Segment decode with leading digits above the committed count blanked.
    always_comb begin
        seg_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (CNT_W'(i) < dc) begin
                seg_nxt[7*i +: 7] = hex_to_seg(dr[i]);
            end
        end
        if (blink_state == BLINK_OFF) begin
            seg_nxt = '1;
        end
    end
`else
    // The committed count is tracked but has no effect on the display here.
    logic dc_unused;
    assign dc_unused = ^dc;

    // Segment decode of every display digit.
    always_comb begin
        seg_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_nxt[7*i +: 7] = hex_to_seg(dr[i]);
        end
        if (blink_state == BLINK_OFF) begin
            seg_nxt = '1;
        end
    end
`endif

    // Output register: reset drives an all-blank bus.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            seg <= '1;
        end else begin
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a cycle-level reference model
// feeding an expected-value queue, plus fixed-pattern checks at key points.
`timescale 1ns/1ps
module tb_hex_display_ctrl;

    localparam int ND = 6;
    localparam int BD = 4;
    localparam int SW = 7 * ND;

`ifdef HEX_LZ_BLANK_EN
    localparam logic [6:0] UNUSED_DIG = 7'b1111111;
`else
    localparam logic [6:0] UNUSED_DIG = 7'b1000000;
`endif
    localparam logic [SW-1:0] ALL_BLANK = {SW{1'b1}};
    localparam logic [SW-1:0] SHOWN_A3  = {{4{UNUSED_DIG}}, 7'b0001000, 7'b0110000};
    localparam logic [SW-1:0] SHOWN_OVF = {7'b0100100, 7'b0110000, 7'b0011001,
                                           7'b0010010, 7'b0000010, 7'b1111000};
    localparam logic [SW-1:0] SHOWN_1   = {{5{UNUSED_DIG}}, 7'b1111001};
    localparam logic [SW-1:0] SHOWN_15  = {{4{UNUSED_DIG}}, 7'b1111001, 7'b0010010};
    localparam logic [SW-1:0] SHOWN_NONE = {6{UNUSED_DIG}};

    logic          clk;
    logic          resetn;
    logic          wr_en;
    logic [3:0]    wr_data;
    logic          commit;
    logic          clear;
    logic          blink_en;
    logic [SW-1:0] seg;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [SW-1:0] seg;
        logic          ovf;
    } exp_t;
    exp_t exp_q[$];

    logic [3:0] m_sh [ND];
    logic [3:0] m_dr [ND];
    int         m_sc;
    int         m_dc;
    logic       m_ovf;
    logic       m_on;
    int         m_bc;

    hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .commit   (commit),
        .clear    (clear),
        .blink_en (blink_en),
        .seg      (seg),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [SW-1:0] model_seg();
        logic [SW-1:0] r;
        r = ALL_BLANK;
        if (m_on) begin
            for (int i = 0; i < ND; i++) begin
`ifdef HEX_LZ_BLANK_EN
                if (i < m_dc) r[7*i +: 7] = dec(m_dr[i]);
`else
                r[7*i +: 7] = dec(m_dr[i]);
`endif
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_sh[i] = 4'h0;
            m_dr[i] = 4'h0;
        end
        m_sc  = 0;
        m_dc  = 0;
        m_ovf = 1'b0;
        m_on  = 1'b1;
        m_bc  = 0;
    endtask

    // One clock cycle: drive inputs, queue the model's prediction, compare after the edge.
    task automatic step(input logic we, input logic [3:0] wd, input logic cm,
                        input logic cl, input logic be, input logic rn);
        exp_t e;
        wr_en    = we;
        wr_data  = wd;
        commit   = cm;
        clear    = cl;
        blink_en = be;
        resetn   = rn;
        if (!rn) begin
            model_reset();
            e.seg = ALL_BLANK;
            e.ovf = 1'b0;
        end else begin
            e.seg = model_seg();
            if (be) begin
                if (m_bc == BD - 1) begin
                    m_bc = 0;
                    m_on = !m_on;
                end else begin
                    m_bc++;
                end
            end else begin
                m_bc = 0;
                m_on = 1'b1;
            end
            if (cm) begin
                for (int i = 0; i < ND; i++) m_dr[i] = m_sh[i];
                m_dc = m_sc;
            end
            if (cl) begin
                for (int i = 0; i < ND; i++) m_sh[i] = 4'h0;
                m_sc  = 0;
                m_ovf = 1'b0;
            end else if (we) begin
                for (int i = ND - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
                m_sh[0] = wd;
                if (m_sc == ND) m_ovf = 1'b1;
                else m_sc++;
            end
            e.ovf = m_ovf;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("seg_model", 64'(seg), 64'(e.seg));
        chk("ovf_model", 64'(overflow), 64'(e.ovf));
    endtask

    initial begin
        resetn   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 4'h0;
        commit   = 1'b0;
        clear    = 1'b0;
        blink_en = 1'b0;
        model_reset();

        // reset held for two cycles, then released
        step(0, 4'h0, 0, 0, 0, 0);
        chk("reset_seg", 64'(seg), 64'(ALL_BLANK));
        step(0, 4'h0, 0, 0, 0, 0);
        chk("reset_ovf", 64'(overflow), 64'(1'b0));
        step(0, 4'h0, 0, 0, 0, 1);
        chk("post_reset_seg", 64'(seg), 64'(SHOWN_NONE));

        // write A, 3 then commit; visible two edges after commit
        step(1, 4'hA, 0, 0, 0, 1);
        step(1, 4'h3, 0, 0, 0, 1);
        step(0, 4'h0, 1, 0, 0, 1);
        chk("commit_lat1", 64'(seg), 64'(SHOWN_NONE));
        step(0, 4'h0, 0, 0, 0, 1);
        chk("commit_a3", 64'(seg), 64'(SHOWN_A3));

        // overflow: clear, write 1..7, commit
        step(0, 4'h0, 0, 1, 0, 1);
        for (int n = 1; n <= 7; n++) begin
            step(1, 4'(n), 0, 0, 0, 1);
            if (n == 6) chk("ovf_at_6", 64'(overflow), 64'(1'b0));
        end
        chk("ovf_at_7", 64'(overflow), 64'(1'b1));
        step(0, 4'h0, 1, 0, 0, 1);
        step(0, 4'h0, 0, 0, 0, 1);
        chk("ovf_digits", 64'(seg), 64'(SHOWN_OVF));
        step(0, 4'h0, 0, 1, 0, 1);
        chk("ovf_cleared", 64'(overflow), 64'(1'b0));

        // commit with same-cycle write shows the old shadow
        step(1, 4'h1, 0, 0, 0, 1);
        step(1, 4'h5, 1, 0, 0, 1);
        step(0, 4'h0, 0, 0, 0, 1);
        chk("commit_wr_old", 64'(seg), 64'(SHOWN_1));
        step(0, 4'h0, 1, 0, 0, 1);
        step(0, 4'h0, 0, 0, 0, 1);
        chk("commit_wr_new", 64'(seg), 64'(SHOWN_15));

        // clear beats a same-cycle write
        step(1, 4'h9, 0, 1, 0, 1);
        step(0, 4'h0, 1, 0, 0, 1);
        step(0, 4'h0, 0, 0, 0, 1);
        chk("clear_wr_empty", 64'(seg), 64'(SHOWN_NONE));

        // blink: 4 cycles shown / 4 cycles blank
        step(1, 4'hA, 0, 0, 0, 1);
        step(1, 4'h3, 0, 0, 0, 1);
        step(0, 4'h0, 1, 0, 0, 1);
        step(0, 4'h0, 0, 0, 0, 1);
        step(0, 4'h0, 0, 0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            step(0, 4'h0, 0, 0, 1, 1);
            chk("blink_phase", 64'(seg), 64'((((k / 4) % 2) == 1) ? ALL_BLANK : SHOWN_A3));
        end
        for (int k = 16; k < 22; k++) step(0, 4'h0, 0, 0, 1, 1);
        step(0, 4'h0, 0, 0, 0, 1);
        chk("blink_drop_lag", 64'(seg), 64'(ALL_BLANK));
        step(0, 4'h0, 0, 0, 0, 1);
        chk("blink_drop_on", 64'(seg), 64'(SHOWN_A3));

        // reset during blink OFF with overflow set
        for (int k = 0; k < 7; k++) step(1, 4'(k + 8), 0, 0, 1, 1);
        chk("pre_rst_ovf", 64'(overflow), 64'(1'b1));
        chk("pre_rst_off", 64'(seg), 64'(ALL_BLANK));
        step(0, 4'h0, 0, 0, 1, 0);
        chk("mid_rst_seg", 64'(seg), 64'(ALL_BLANK));
        chk("mid_rst_ovf", 64'(overflow), 64'(1'b0));
        for (int k = 0; k < 5; k++) begin
            step(0, 4'h0, 0, 0, 1, 1);
            chk("rst_blink_phase", 64'(seg), 64'((k < 4) ? SHOWN_NONE : ALL_BLANK));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

- Parametrised multi-digit 7-segment hex display controller for the PS2 display path.
- Hex nibbles (e.g. decoded keyboard scan codes) are shifted into a shadow register, then committed to the visible display. Display tracks digit count, optionally blanks unused leading digits, and can blink.
- Sits between the PS/2 receive logic and the board HEX outputs; drives NUM_DIGITS active-low segment groups from one registered bus.

## Interface
- NUM_DIGITS, 6, number of digits driven (1..8)
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=1)
- clk  input  1  system clock; all logic on rising edge
- resetn  input  1  synchronous, active-low reset
- wr_en  input  1  shift wr_data into shadow digit 0 this cycle
- wr_data  input  4  hex nibble to shift in
- commit  input  1  copy shadow register and count to visible display
- clear  input  1  zero shadow register, shadow count and overflow
- blink_en  input  1  enable display blinking
- seg  output  7*NUM_DIGITS  segments; digit i on seg[7i+6:7i], bit0=a..bit6=g, active-low
- overflow  output  1  sticky: more than NUM_DIGITS nibbles written since last clear/reset

## Operation
- Shadow register sh[NUM_DIGITS-1:0] (4 bits each) and shadow count sc (0..NUM_DIGITS, saturating).
- wr_en: sh[i] <= sh[i-1] for i>0, sh[0] <= wr_data; sc <= min(sc+1, NUM_DIGITS); the write that would make the count exceed NUM_DIGITS sets overflow. The oldest digit is discarded.
- commit: display register dr <= sh and dc <= sc, using pre-edge values. A write in the same cycle updates sh only, so it is not visible until the next commit.
- clear: sh <= 0, sc <= 0, overflow <= 0. clear beats wr_en in the same cycle, and the write is dropped. clear with commit: commit takes the old sh/sc, then the shadow is cleared.
- Decode per digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (bits g..a). Blank = 1111111.
- Blink has two states, ON and OFF:
  - Counter bc runs 0..BLINK_DIV-1; each time bc wraps, the state toggles.
  - While blink_en=0: bc=0, state forced to ON.
  - In OFF, all digits are blank.
  - Rising blink_en starts in ON with bc=0.
- Reset (resetn=0 at an edge, including mid-operation): sh=0, sc=0, dr=0, dc=0, overflow=0, bc=0, blink ON, seg all 1 (blank) on the following cycle.

## Timing
- seg is registered. Inputs sampled at edge E update sh/dr at E; seg reflects the new dr at edge E+1. Commit-to-seg latency is 2 edges.
- overflow is registered and asserts at the same edge as the overflowing write.
- Blink transitions on seg lag the internal state change by 1 cycle. With blink_en=1, each ON/OFF phase lasts exactly BLINK_DIV cycles.
- No backpressure: writes are accepted every cycle, back-to-back.

## Configuration
- HEX_LZ_BLANK_EN defined: digit i is blank when i >= dc. After reset or an empty commit, all digits are blank. A committed "7" after a clear shows only digit 0.
- Undefined: every digit always shows the decode of dr[i], so reset shows all "0" (1000000). dc is still kept but unused for display.

## Test plan
- Reset: hold resetn=0 for 2 cycles, then release -> seg all 1s (HEX_LZ_BLANK_EN) or every digit 1000000 (undefined); overflow=0.
- Writes + commit: write A, 3, then commit -> 2 edges later digit1=0001000, digit0=0110000; digits 2..5 blank (macro defined).
- Overflow: write 7 nibbles 1..7, then commit -> digits 5..0 show 2..7; overflow=1 from the 7th write; clear drops it to 0 next cycle.
- Simultaneous events:
  - commit+wr_en(5) in the same cycle shows the old shadow; 5 appears only after a second commit.
  - clear+wr_en leaves sc=0.
- Blink: BLINK_DIV=4, blink_en=1 -> seg alternates 4 cycles digits/4 cycles blank; dropping blink_en restores digits 1 cycle after the state is forced ON.
- Reset mid-operation: resetn=0 during blink OFF with overflow=1 -> next cycle seg blank-reset value, overflow=0, blink ON with counter 0.
